fifo_rd_ctrl: RTL and testbench

Read-side pointer and status controller for the dual-clock asynchronous FIFO, in the rclk domain. Consumes the write pointer after it has been synchronized into the read domain (Gray, ADDR_SIZE+1 bits). Generates the binary RAM read address, the Gray read pointer that is synchronized back to the write domain, and the empty, almost-empty and fill-level status. It is the read-side counterpart of the write-pointer/full logic.

---
 rtl/async_fifo_pkg.sv | 32 +++
 rtl/gray2bin.sv | 27 ++
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the dual-clock asynchronous FIFO pointer logic.
//   ADDR_SIZE_DEF : default RAM address width (FIFO depth = 2**ADDR_SIZE_DEF)
//   PTR_W         : pointer width for the default build (one extra lap bit)
//   CONV_W        : working width of the Gray/binary helper functions
//   bin2gray()    : binary -> reflected Gray code
//   gray2bin()    : reflected Gray code -> binary (XOR prefix from the MSB)
// Both helpers accept any pointer width up to CONV_W bits. The caller
// zero-extends the value into the function and truncates the result back.
// Leading zeros are neutral for both conversions.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned ADDR_SIZE_DEF = 8;
    localparam int unsigned PTR_W         = ADDR_SIZE_DEF + 1;
    localparam int unsigned CONV_W        = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int unsigned i = CONV_W - 1; i > 0; i--) begin
            bin[i-1] = bin[i] ^ gray[i-1];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter of width W. Each binary bit
// is the XOR of all Gray bits at or above it. This module is shared by the
// read-side empty/level logic and the write-side full/level logic.
// Ports:
//   gray : input  [W-1:0]  Gray-coded pointer
//   bin  : output [W-1:0]  equivalent binary pointer
// -----------------------------------------------------------------------------
module gray2bin
    import async_fifo_pkg::*;
#(
    parameter int unsigned W = PTR_W
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin      = '0;
        bin[W-1] = gray[W-1];
        for (int unsigned i = W - 1; i > 0; i--) begin
            bin[i-1] = bin[i] ^ gray[i-1];
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side pointer and status controller of the dual-clock asynchronous FIFO
// (rclk domain). Keeps the binary read pointer and publishes its Gray form for
// the write-domain synchronizer. It derives empty, almost-empty and the fill
// level from the synchronized Gray write pointer.
//
// Parameters:
//   ADDR_SIZE : RAM address width, FIFO depth = 2**ADDR_SIZE
//   AE_THRESH : ralmost_empty asserts when the fill level is <= AE_THRESH
//
// Ports:
//   rclk          : in   read-domain clock
//   rrst_n        : in   asynchronous active-low reset
//   rinc          : in   read request (pop only when the FIFO is not empty)
//   rq2_wptr      : in   [ADDR_SIZE:0] Gray write pointer, synchronized into rclk
//   raddr         : out  [ADDR_SIZE-1:0] binary RAM read address
//   rptr          : out  [ADDR_SIZE:0] registered Gray read pointer
//   rempty        : out  FIFO empty (registered)
//   ralmost_empty : out  fill level <= AE_THRESH (registered)
//   rlevel        : out  [ADDR_SIZE:0] registered fill level (0 .. 2**ADDR_SIZE)
//
// Optional feature, macro FIFO_RD_UNDERFLOW_EN:
//   rerr_clr      : in   clears the sticky underflow flag
//   runderflow    : out  sticky flag, set by any rinc while rempty is high.
//                        A set in the same cycle as rerr_clr takes priority.
//
// The write pointer arrives at least two rclk cycles late. Empty and level
// can therefore only under-report occupancy, which is safe on the read side.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rinc,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
`ifdef FIFO_RD_UNDERFLOW_EN
    input  logic                 rerr_clr,
    output logic                 runderflow,
`endif
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [ADDR_SIZE:0]   rlevel
);

    localparam int unsigned W = ADDR_SIZE + 1;

    logic [W-1:0] rbin;
    logic [W-1:0] rbin_next;
    logic [W-1:0] rgray_next;
    logic [W-1:0] wbin_s;
    logic [W-1:0] level_next;
    logic         rpop;
    logic         rempty_next;
    logic         ralmost_empty_next;

    gray2bin #(
        .W (W)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // All status is computed from the next-state pointer. The pop that drains
    // the last entry therefore raises rempty on the same edge, with no bubble.
    // The modulo-2**W difference keeps the level correct across pointer wrap.
    always_comb begin
        rpop               = rinc & ~rempty;
        rbin_next          = rbin + W'(rpop);
        rgray_next         = W'(bin2gray(CONV_W'(rbin_next)));
        level_next         = wbin_s - rbin_next;
        rempty_next        = (rgray_next == rq2_wptr);
        ralmost_empty_next = (level_next <= W'(AE_THRESH));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= rempty_next;
            ralmost_empty <= ralmost_empty_next;
            rlevel        <= level_next;
        end
    end

    // RAM address comes straight from the register, so there is no
    // combinational path from rinc to the RAM.
    assign raddr = rbin[ADDR_SIZE-1:0];

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end else if (rerr_clr) begin
            runderflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    localparam int unsigned AS  = 4;
    localparam int unsigned AET = 4;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        rinc = 1'b0;
    logic [4:0]  rq2_wptr = '0;
    logic [3:0]  raddr;
    logic [4:0]  rptr;
    logic        rempty;
    logic        ralmost_empty;
    logic [4:0]  rlevel;
`ifdef FIFO_RD_UNDERFLOW_EN
    logic        rerr_clr = 1'b0;
    logic        runderflow;
    bit          m_uf;
`endif

    int          nvec = 0;
    int          nfail = 0;
    bit          chk_en = 0;

    // Model state: number of entries written (as presented to the reader)
    // and read, both modulo 32.
    logic [4:0]  w_drv = '0;
    logic [4:0]  m_r;
    logic [4:0]  m_w;
    logic [4:0]  m_lvl;

    logic [4:0]  c_lvl;
    logic [4:0]  prev_rptr;
    logic [4:0]  prev_mr;

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(
        .ADDR_SIZE (AS),
        .AE_THRESH (AET)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
`ifdef FIFO_RD_UNDERFLOW_EN
        .rerr_clr      (rerr_clr),
        .runderflow    (runderflow),
`endif
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
    );

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pop happens when a read is requested and the
    // occupancy the reader knows about is non-zero.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_r = '0;
            m_w = '0;
`ifdef FIFO_RD_UNDERFLOW_EN
            m_uf = 0;
`endif
        end else begin
            m_lvl = m_w - m_r;
`ifdef FIFO_RD_UNDERFLOW_EN
            if (rinc && m_lvl == 0) m_uf = 1;
            else if (rerr_clr) m_uf = 0;
`endif
            if (rinc && m_lvl != 0) m_r = m_r + 5'd1;
            m_w = w_drv;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            prev_rptr = '0;
            prev_mr   = '0;
        end else if (chk_en) begin
            c_lvl = m_w - m_r;
            chk("rlevel", rlevel, c_lvl);
            chk("rempty", rempty, c_lvl == 0);
            chk("ralmost_empty", ralmost_empty, c_lvl <= 5'(AET));
            chk("raddr", raddr, m_r[3:0]);
            chk("rptr", rptr, g(m_r));
            chk("rptr_bits_changed", $countones(rptr ^ prev_rptr), (m_r != prev_mr) ? 1 : 0);
`ifdef FIFO_RD_UNDERFLOW_EN
            chk("runderflow", runderflow, m_uf);
`endif
            prev_rptr = rptr;
            prev_mr   = m_r;
        end
    end

    task automatic step(input bit ri, input logic [4:0] wb);
        @(negedge rclk);
        #1;
        rinc     = ri;
        w_drv    = wb;
        rq2_wptr = g(wb);
        @(posedge rclk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        w_drv    = '0;
        rq2_wptr = '0;
        @(negedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] nb;
        logic [4:0] d;
        bit         ri;

        #12;
        @(negedge rclk);
        #1;
        rrst_n = 1'b1;
        chk_en = 1;

        // Move away from the reset state, then reset mid-cycle.
        step(0, 5'd2);
        step(1, 5'd2);
        chk("pre_reset_rlevel", rlevel, 1);
        chk("pre_reset_rptr", rptr, 5'b00001);
        #2;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        w_drv    = '0;
        rq2_wptr = '0;
        #1;
        chk("rst_rempty", rempty, 1);
        chk("rst_ralmost_empty", ralmost_empty, 1);
        chk("rst_rptr", rptr, 5'b00000);
        chk("rst_raddr", raddr, 0);
        chk("rst_rlevel", rlevel, 0);
`ifdef FIFO_RD_UNDERFLOW_EN
        chk("rst_runderflow", runderflow, 0);
`endif
        @(negedge rclk);
        #1;
        rrst_n = 1'b1;

        // Fill with three entries, then drain them.
        step(0, 5'd3);
        chk("fill_rempty", rempty, 0);
        chk("fill_rlevel", rlevel, 3);
        chk("fill_ralmost_empty", ralmost_empty, 1);
        for (int i = 0; i < 3; i++) begin
            chk("drain_raddr", raddr, i);
            step(1, 5'd3);
        end
        chk("drain_rempty", rempty, 1);
        chk("drain_rptr", rptr, 5'b00010);
        chk("drain_raddr_end", raddr, 3);

        // Reads while empty are ignored.
        for (int i = 0; i < 5; i++) begin
            step(1, 5'd3);
            chk("uf_rptr", rptr, 5'b00010);
            chk("uf_raddr", raddr, 3);
        end
`ifdef FIFO_RD_UNDERFLOW_EN
        chk("uf_set", runderflow, 1);
        step(0, 5'd3);
        chk("uf_sticky", runderflow, 1);
        rerr_clr = 1'b1;
        step(0, 5'd3);
        rerr_clr = 1'b0;
        chk("uf_clear", runderflow, 0);
`endif

        // Full FIFO, then pop down to the almost-empty boundary.
        reset_pulse();
        step(0, 5'd16);
        chk("full_rlevel", rlevel, 16);
        chk("full_ralmost_empty", ralmost_empty, 0);
        chk("full_rempty", rempty, 0);
        for (int i = 0; i < 11; i++) step(1, 5'd16);
        chk("ae_lvl5", rlevel, 5);
        chk("ae_lvl5_flag", ralmost_empty, 0);
        step(1, 5'd16);
        chk("ae_lvl4", rlevel, 4);
        chk("ae_lvl4_flag", ralmost_empty, 1);
        chk("ae_raddr", raddr, 12);

        // Pop while the write pointer advances in the same cycle.
        for (int i = 0; i < 3; i++) step(1, 5'd16);
        chk("sim_pre_rlevel", rlevel, 1);
        step(1, 5'd17);
        chk("sim_rempty", rempty, 0);
        chk("sim_rlevel", rlevel, 1);
        chk("sim_rptr", rptr, 5'b11000);
        chk("sim_raddr", raddr, 0);

        // Randomized traffic across many pointer wraps.
        for (int i = 0; i < 600; i++) begin
            d  = w_drv - m_r;
            nb = w_drv;
            if ($urandom_range(0, 1) == 1 && d < 5'd16) nb = w_drv + 5'd1;
            ri = ($urandom_range(0, 99) < 55);
`ifdef FIFO_RD_UNDERFLOW_EN
            rerr_clr = ($urandom_range(0, 7) == 0);
`endif
            step(ri, nb);
        end

        @(negedge rclk);
        #2;
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
